load_store_unit: RTL and testbench

- Memory-access stage directly downstream of the ALU.
- Takes the effective address the ALU computes for LB/LW/SB/SW (rs1 + imm), plus the store data and destination register.
- Runs a single-outstanding req/ack transaction on the data-memory/peripheral bus (RAM, UART registers).
- Returns sign-extended load data to writeback and reports misalignment and bus-timeout faults.

---
 rtl/riscv_pkg.sv | 36 +++
 rtl/lsu_lane_align.sv | 36 +++
 rtl/load_store_unit.sv | 137 +++++++++++++
 tb/tb_load_store_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared ALU op codes, LSU state encoding and byte-lane helpers.
// Pure definitions; no timing or flow control of its own.
package riscv_pkg;

  localparam logic [5:0] OP_LB = 6'b010011;
  localparam logic [5:0] OP_LW = 6'b010101;
  localparam logic [5:0] OP_SB = 6'b011000;
  localparam logic [5:0] OP_SW = 6'b011010;

  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RESP  = 2'd2,
    FAULT = 2'd3
  } lsu_state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LW) || (op == OP_SB) || (op == OP_SW);
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SW);
  endfunction

  // Word ops must sit on a 4-byte boundary; byte ops may use any lane.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] byte_off);
    return ((op == OP_LW) || (op == OP_SW)) && (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store replication/strobes and load byte extract + sign extend.
// Purely combinational, zero latency, no flow control.
module lsu_lane_align
  import riscv_pkg::*;
(
  input  logic [5:0]        op,
  input  logic [1:0]        byte_off,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  output logic [31:0]       st_wdata,
  output logic [STRB_W-1:0] st_wstrb,
  output logic [31:0]       ld_data
);

  logic [7:0] ld_byte;

  always_comb begin
    st_wdata = 32'h0;
    st_wstrb = '0;
    ld_byte  = rdata[{byte_off, 3'b000} +: 8];
    ld_data  = rdata;

    if (op == OP_SB) begin
      st_wdata = {4{wdata[7:0]}};
      st_wstrb = 4'b0001 << byte_off;
    end else if (op == OP_SW) begin
      st_wdata = wdata;
      st_wstrb = 4'b1111;
    end

    if (op == OP_LB) begin
      ld_data = {{24{ld_byte[7]}}, ld_byte};
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one outstanding req/ack bus op, sign-extended load writeback, fault report.
// Min latency 2 cycles accept->wb_valid; req_ready low (busy) from accept until the op retires.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [5:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              req_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              done,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr,
  output logic              busy
);

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_t        state_q, state_d;
  logic              accept;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic [31:0]       rdata_q;
  logic [15:0]       cnt_q;
  logic [ADDR_W-1:0] fault_addr_q;

  logic [31:0]       st_wdata;
  logic [3:0]        st_wstrb;
  logic [31:0]       ld_data;

  assign accept = (state_q == IDLE) && req_valid && is_mem_op(req_op);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = is_misaligned(req_op, req_addr[1:0]) ? FAULT : BUS;
      end
      BUS: begin
        // Ack on the final counted cycle still completes the transaction.
        if (mem_ack)                state_d = RESP;
        else if (cnt_q == LAST_CNT) state_d = FAULT;
      end
      RESP:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      fault_addr_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rd_q    <= req_rd;
      end
      cnt_q <= (state_q == BUS && state_d == BUS) ? cnt_q + 16'd1 : 16'd0;
      if (state_q == BUS && mem_ack) rdata_q <= mem_rdata;
      // Misalignment faults straight from IDLE, before addr_q has been loaded.
      if (state_d == FAULT && state_q != FAULT)
        fault_addr_q <= (state_q == IDLE) ? req_addr : addr_q;
    end
  end

  lsu_lane_align u_lane_align (
    .op       (op_q),
    .byte_off (addr_q[1:0]),
    .wdata    (wdata_q),
    .rdata    (rdata_q),
    .st_wdata (st_wdata),
    .st_wstrb (st_wstrb),
    .ld_data  (ld_data)
  );

  always_comb begin
    req_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    mem_req   = (state_q == BUS);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    wb_valid  = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 32'h0;
    done      = (state_q == RESP) || (state_q == FAULT);
    fault     = (state_q == FAULT);

    if (state_q == BUS) begin
      mem_we    = is_store(op_q);
      mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
      mem_wdata = st_wdata;
      mem_wstrb = st_wstrb;
    end

    if (state_q == RESP && is_load(op_q) && rd_q != 5'd0) begin
      wb_valid = 1'b1;
      wb_rd    = rd_q;
      wb_data  = ld_data;
    end
  end

  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 4-cycle bus timeout.
module tb_load_store_unit;

  localparam logic [5:0] LB = 6'b010011;
  localparam logic [5:0] LW = 6'b010101;
  localparam logic [5:0] SB = 6'b011000;
  localparam logic [5:0] SW = 6'b011010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [5:0]  req_op = 6'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        req_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done, fault, busy;
  logic [31:0] fault_addr;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .req_ready(req_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .done(done), .fault(fault), .fault_addr(fault_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if ({mem_req, mem_we, mem_wstrb, busy, done, fault, wb_valid} !== 10'd0)
      $display("FAIL reset_ctrl: got %b want 0", {mem_req, mem_we, mem_wstrb, busy, done, fault, wb_valid}); else n_pass++;
    n_checks++; if ({mem_addr, mem_wdata, wb_data, fault_addr, wb_rd} !== '0)
      $display("FAIL reset_data: got %h %h %h %h want all 0", mem_addr, mem_wdata, wb_data, fault_addr); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    issue(LW, 32'h0000_1004, 32'h0, 5'd5);
    n_checks++; if ({mem_req, mem_we, mem_wstrb, busy, req_ready} !== 8'b1_0_0000_1_0)
      $display("FAIL lw_bus_ctrl: got %b want 10000010", {mem_req, mem_we, mem_wstrb, busy, req_ready}); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0000_1004) $display("FAIL lw_addr: got %h want 00001004", mem_addr); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    n_checks++; if ({wb_valid, done, mem_req, fault} !== 4'b1100)
      $display("FAIL lw_resp_ctrl: got %b want 1100", {wb_valid, done, mem_req, fault}); else n_pass++;
    n_checks++; if (wb_data !== 32'hDEAD_BEEF) $display("FAIL lw_data: got %h want deadbeef", wb_data); else n_pass++;
    n_checks++; if (wb_rd !== 5'd5) $display("FAIL lw_rd: got %0d want 5", wb_rd); else n_pass++;
    tick();
    n_checks++; if ({wb_valid, done, req_ready} !== 3'b001)
      $display("FAIL lw_retire: got %b want 001", {wb_valid, done, req_ready}); else n_pass++;
  endtask

  task automatic test_lb(input logic [31:0] addr, input logic [31:0] exp);
    issue(LB, addr, 32'h0, 5'd3);
    n_checks++; if (mem_addr !== {addr[31:2], 2'b00}) $display("FAIL lb_addr: got %h want %h", mem_addr, {addr[31:2], 2'b00}); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 32'h80FF_0000;
    tick();
    mem_ack = 1'b0;
    n_checks++; if (wb_valid !== 1'b1 || wb_data !== exp)
      $display("FAIL lb_data: got vld=%b %h want 1 %h", wb_valid, wb_data, exp); else n_pass++;
    tick();
  endtask

  task automatic test_load_x0();
    issue(LW, 32'h0000_1000, 32'h0, 5'd0);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    n_checks++; if ({done, wb_valid} !== 2'b10) $display("FAIL x0_no_wb: got %b want 10", {done, wb_valid}); else n_pass++;
    tick();
  endtask

  task automatic test_sb_wait();
    issue(SB, 32'h0000_2001, 32'h1234_56A5, 5'd0);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({mem_req, mem_we, mem_wstrb} !== 6'b11_0010 || mem_wdata !== 32'hA5A5_A5A5 || mem_addr !== 32'h0000_2000)
        $display("FAIL sb_bus_%0d: got %b %h %h want 110010 a5a5a5a5 00002000", i, {mem_req, mem_we, mem_wstrb}, mem_wdata, mem_addr);
      else n_pass++;
      if (i == 3) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    n_checks++; if ({done, wb_valid, fault, mem_req} !== 4'b1000)
      $display("FAIL sb_retire: got %b want 1000", {done, wb_valid, fault, mem_req}); else n_pass++;
    tick();
  endtask

  task automatic test_misaligned();
    issue(SW, 32'h0000_3002, 32'hCAFE_F00D, 5'd0);
    n_checks++; if ({mem_req, fault, done, req_ready, wb_valid} !== 5'b01100)
      $display("FAIL mis_ctrl: got %b want 01100", {mem_req, fault, done, req_ready, wb_valid}); else n_pass++;
    n_checks++; if (fault_addr !== 32'h0000_3002) $display("FAIL mis_addr: got %h want 00003002", fault_addr); else n_pass++;
    tick();
    n_checks++; if ({req_ready, fault, done, mem_req} !== 4'b1000 || fault_addr !== 32'h0000_3002)
      $display("FAIL mis_after: got %b %h want 1000 00003002", {req_ready, fault, done, mem_req}, fault_addr); else n_pass++;
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    issue(LW, 32'h0000_4000, 32'h0, 5'd7);
    for (int i = 0; i < 10; i++) begin
      if (!mem_req) break;
      req_cycles++;
      tick();
    end
    n_checks++; if (req_cycles !== 4) $display("FAIL to_req_len: got %0d want 4", req_cycles); else n_pass++;
    n_checks++; if ({fault, done, wb_valid, mem_req} !== 4'b1100 || fault_addr !== 32'h0000_4000)
      $display("FAIL to_fault: got %b %h want 1100 00004000", {fault, done, wb_valid, mem_req}, fault_addr); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    n_checks++; if ({wb_valid, done, mem_req, req_ready} !== 4'b0001)
      $display("FAIL to_late_ack: got %b want 0001", {wb_valid, done, mem_req, req_ready}); else n_pass++;
    tick();
    mem_ack = 1'b0;
    n_checks++; if ({wb_valid, done, mem_req, req_ready} !== 4'b0001)
      $display("FAIL to_late_ack2: got %b want 0001", {wb_valid, done, mem_req, req_ready}); else n_pass++;
  endtask

  task automatic test_illegal_op();
    issue(6'b000001, 32'h0000_1000, 32'h0, 5'd2);
    n_checks++; if ({req_ready, mem_req, done} !== 3'b100)
      $display("FAIL illegal_op: got %b want 100", {req_ready, mem_req, done}); else n_pass++;
  endtask

  task automatic test_reset_mid_bus();
    issue(LW, 32'h0000_5000, 32'h0, 5'd4);
    n_checks++; if (mem_req !== 1'b1) $display("FAIL rst_bus_entry: got %b want 1", mem_req); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if ({mem_req, req_ready, done, fault, wb_valid} !== 5'b01000)
      $display("FAIL rst_mid_bus: got %b want 01000", {mem_req, req_ready, done, fault, wb_valid}); else n_pass++;
    issue(LW, 32'h0000_5008, 32'h0, 5'd9);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ack = 1'b0;
    n_checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd9 || wb_data !== 32'h0BAD_F00D)
      $display("FAIL rst_next_lw: got %b %0d %h want 1 9 0badf00d", wb_valid, wb_rd, wb_data); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int wb_cnt = 0;
    int first_wb = -1;
    int second_wb = -1;
    req_valid = 1'b1; req_op = LW; req_addr = 32'h0000_6000; req_rd = 5'd11;
    mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (wb_valid) begin
        wb_cnt++;
        if (first_wb < 0) first_wb = c; else second_wb = c;
      end
    end
    req_valid = 1'b0; mem_ack = 1'b0;
    n_checks++; if (wb_cnt !== 2) $display("FAIL b2b_count: got %0d want 2", wb_cnt); else n_pass++;
    n_checks++; if (first_wb !== 2 || second_wb !== 5)
      $display("FAIL b2b_spacing: got %0d,%0d want 2,5", first_wb, second_wb); else n_pass++;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb(32'h0000_1003, 32'hFFFF_FF80);
    test_lb(32'h0000_1002, 32'hFFFF_FFFF);
    test_load_x0();
    test_sb_wait();
    test_misaligned();
    test_timeout();
    test_illegal_op();
    test_reset_mid_bus();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
